line_consistency_checker: RTL and testbench
===========================================

# line_consistency_checker

Streaming consistency checker for the nonogram solver. It holds the current partial board as a cell-indexed known/value bitmap. Candidate line assignments arrive as a stream of {value, cell index} entries. Each candidate is checked against the board and against itself for contradictions, and in commit mode a consistent candidate is merged into the board. It sits between the BRAM line reader and the solver control FSM. It replaces pairwise two-register line comparison with an any-line-vs-board check of configurable size.

## Interface
- `IDX_W`, default 12: cell index width carried in each entry.
- `CELLS`, default 256: board cells tracked, with `CELLS <= 2**IDX_W`.
- `MAX_LEN`, default 64: maximum entries per line.
- `CNT_W`, default `$clog2(MAX_LEN+1)`: width of the entry counter.

- `clk`  in  1: clock.
- `rst_n`  in  1: synchronous, active-low reset.
- `clear`  in  1: wipes the board bitmap. Honoured only in IDLE.
- `in_valid`  in  1: entry valid.
- `in_ready`  out  1: entry accepted when `in_valid && in_ready`.
- `in_entry`  in  IDX_W+1: bit IDX_W is the cell value, bits [IDX_W-1:0] are the cell index.
- `in_last`  in  1: marks the final entry of a line.
- `in_commit`  in  1: line mode, 1 = check and commit. Sampled on the first beat of a line.
- `res_valid`  out  1: result available.
- `res_ready`  in  1: result consumed when `res_valid && res_ready`.
- `res_ok`  out  1: line is consistent and has no errors.
- `res_err_range`  out  1: some entry had index >= CELLS.
- `res_err_len`  out  1: more than MAX_LEN entries received.
- `res_count`  out  CNT_W: entries received, saturating at MAX_LEN.
- `res_conflict_idx`  out  IDX_W: index of the first conflicting cell (see Configuration).
- `busy`  out  1: high whenever the FSM is not in IDLE.

## Operation
- Board state: `known[CELLS]` and `val[CELLS]`. Line-local state: `tknown[CELLS]` and `tval[CELLS]`.
- FSM states: IDLE, STREAM, COMMIT, RESULT.
- IDLE:
  - `in_ready=1`.
  - `clear` zeroes `known` in one cycle.
  - If `clear` and a beat coincide, the clear takes effect first and the beat is checked against the empty board.
  - The first accepted beat latches `in_commit`, zeroes `tknown`, and is processed.
  - If that beat has `in_last`, go to COMMIT when the commit flag is set and ok; otherwise go to RESULT. Without `in_last`, go to STREAM.
- Per beat, checks in priority order:
  1. count >= MAX_LEN sets `err_len`. The entry is dropped and not checked.
  2. idx >= CELLS sets `err_range`. The entry is dropped.
  3. Conflict if `known[idx] && val[idx]!=v`, or `tknown[idx] && tval[idx]!=v`.
  4. Otherwise set `tknown[idx]=1` and `tval[idx]=v`.
- Count increments on every beat, saturating at MAX_LEN.
- ok = no conflict, no `err_range`, no `err_len`.
- STREAM: `in_ready=1`. On `in_last`, exit as described for IDLE.
- COMMIT, one cycle:
  - `known |= tknown`.
  - `val = (val & ~tknown) | (tval & tknown)`.
  - Then go to RESULT.
- A failing line never modifies the board. Check-only lines never modify it.
- RESULT: `in_ready=0`. Result outputs are stable while `res_valid=1`. Go to IDLE on `res_ready`.
- Duplicate entries with the same value are legal and are not conflicts.

## Timing
- Reset values:
  - `in_ready=1`. `res_valid=0`. `busy=0`.
  - `res_ok`, `res_err_*`, `res_count` and `res_conflict_idx` are all 0.
  - `known` and `tknown` are cleared. FSM in IDLE.
- Latency, counted from the cycle the `in_last` beat is accepted:
  - Check-only: `res_valid` rises the next cycle.
  - Passing commit line: `res_valid` rises 2 cycles later. COMMIT is the intermediate cycle.
- The earliest next line is accepted in the cycle after the result handshake.
- `in_ready` is a pure function of FSM state and has no combinational path from `in_valid`.
- The board read for a beat sees every earlier committed line. Commit completes before `res_valid` rises.
- `rst_n` low mid-line or mid-result discards the line and the result, clears the board, and takes effect on the next edge.
- `clear` outside IDLE is ignored. It is not queued.

## Configuration
- `CHECKER_CONFLICT_INFO_EN`:
  - Defined: `res_conflict_idx` registers the index of the first conflicting entry of the line. It is held with the result.
  - Undefined: the port exists but is tied to 0. The capture register and the first-conflict flag are not built.
- `res_ok` behaviour is identical either way.

## Structure
- Package `nonogram_pkg` holds:
  - `typedef struct packed {logic value; logic [IDX_W-1:0] idx;} cell_entry_t`.
  - The state enum `chk_state_t`.
  - The default IDX_W, CELLS and MAX_LEN constants shared with the BRAM reader.
- One sub-module is natural: `cell_bitmap`, a CELLS-wide known/value register pair with:
  - a one-cycle clear,
  - an indexed read,
  - an indexed set,
  - a bulk merge.
- Instantiate it twice: once for the board, once for the line-local state.

## Test plan
- Check-only on an empty board: entries (3,1),(5,0),(7,1) with last on the third. Expect `res_ok=1` and `count=3`, and `known` stays 0.
- Commit (3,1), then check (3,0). Expect `res_ok=0` and, with the macro defined, `res_conflict_idx=3`. Expect `val[3]` still 1.
- Within-line contradiction (4,1),(4,0) in commit mode. Expect `res_ok=0`, and board bit 4 stays unknown.
- Out-of-range entry idx=300 with CELLS=256. Expect `err_range=1` and `ok=0`. Expect `count` to include the beat.
- MAX_LEN+2 entries. Expect `err_len=1` and `count=MAX_LEN`. Then hold `res_ready=0` for 5 cycles: outputs stable and `in_ready=0`.
- Drive `rst_n=0` mid-STREAM after committed lines. Then on check (3,0), expect `ok=1`, confirming the board was cleared. Separately, `clear` during RESULT is ignored.

Source files
------------

// File: rtl/nonogram_pkg.sv
`default_nettype none
// ============================================================================
// Module  : nonogram_pkg
// Purpose : Shared types and default geometry for the nonogram line checker
//           and the BRAM line reader.
// Revision: 1.0 - initial release
// ============================================================================
package nonogram_pkg;

  localparam int c_IDX_W   = 12;
  localparam int c_CELLS   = 256;
  localparam int c_MAX_LEN = 64;

  typedef struct packed {
    logic               value;
    logic [c_IDX_W-1:0] idx;
  } cell_entry_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_COMMIT = 2'd2,
    S_RESULT = 2'd3
  } chk_state_t;

endpackage
`default_nettype wire

// File: rtl/cell_bitmap.sv
`default_nettype none
// ============================================================================
// Module  : cell_bitmap
// Purpose : CELLS-wide known/value register pair with one-cycle clear,
//           indexed read, indexed set and bulk merge.
// Revision: 1.0 - initial release
// ============================================================================
module cell_bitmap
  import nonogram_pkg::*;
#(
  parameter int IDX_W = c_IDX_W,
  parameter int CELLS = c_CELLS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_set_en,
  input  logic [IDX_W-1:0] i_set_idx,
  input  logic             i_set_val,
  input  logic             i_merge_en,
  input  logic [CELLS-1:0] i_merge_known,
  input  logic [CELLS-1:0] i_merge_val,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic             o_rd_known,
  output logic             o_rd_val,
  output logic [CELLS-1:0] o_known,
  output logic [CELLS-1:0] o_val
);

  localparam int c_AW = (CELLS > 1) ? $clog2(CELLS) : 1;

  logic [CELLS-1:0] r_known;
  logic [CELLS-1:0] r_val;
  logic [CELLS-1:0] w_known_nxt;
  logic [CELLS-1:0] w_val_nxt;
  logic             w_rd_in;
  logic             w_set_in;
  logic [c_AW-1:0]  w_rd_a;
  logic [c_AW-1:0]  w_set_a;

  assign w_rd_a   = i_rd_idx[c_AW-1:0];
  assign w_set_a  = i_set_idx[c_AW-1:0];
  assign w_rd_in  = (32'(i_rd_idx) < 32'(CELLS));
  assign w_set_in = (32'(i_set_idx) < 32'(CELLS));

  assign o_rd_known = w_rd_in && r_known[w_rd_a];
  assign o_rd_val   = w_rd_in && r_val[w_rd_a];
  assign o_known    = r_known;
  assign o_val      = r_val;

  // Clear, then merge, then set: a clear and a set in the same cycle
  // leaves exactly the newly set cell known.
  always_comb begin
    w_known_nxt = r_known;
    w_val_nxt   = r_val;
    if (i_clear) begin
      w_known_nxt = '0;
    end
    if (i_merge_en) begin
      w_known_nxt = w_known_nxt | i_merge_known;
      w_val_nxt   = (w_val_nxt & ~i_merge_known) | (i_merge_val & i_merge_known);
    end
    if (i_set_en && w_set_in) begin
      w_known_nxt[w_set_a] = 1'b1;
      w_val_nxt[w_set_a]   = i_set_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_known <= '0;
      r_val   <= '0;
    end else begin
      r_known <= w_known_nxt;
      r_val   <= w_val_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/line_consistency_checker.sv
`default_nettype none
// ============================================================================
// Module  : line_consistency_checker
// Purpose : Streams candidate line entries, checks them against the board and
//           themselves, and merges consistent commit lines into the board.
//           Option macro: CHECKER_CONFLICT_INFO_EN (first-conflict index).
// Revision: 1.0 - initial release
// ============================================================================
module line_consistency_checker
  import nonogram_pkg::*;
#(
  parameter int IDX_W   = c_IDX_W,
  parameter int CELLS   = c_CELLS,
  parameter int MAX_LEN = c_MAX_LEN,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [IDX_W:0]   i_in_entry,
  input  logic             i_in_last,
  input  logic             i_in_commit,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic             o_res_ok,
  output logic             o_res_err_range,
  output logic             o_res_err_len,
  output logic [CNT_W-1:0] o_res_count,
  output logic [IDX_W-1:0] o_res_conflict_idx,
  output logic             o_busy
);

  chk_state_t r_state;
  chk_state_t w_state_nxt;

  logic [CNT_W-1:0] r_count;
  logic             r_err_len;
  logic             r_err_range;
  logic             r_conflict;
  logic             r_ok;
  logic             r_commit;

  logic             w_beat;
  logic             w_first;
  logic             w_clear_brd;
  logic [IDX_W-1:0] w_idx;
  logic             w_v;
  logic             w_in_range;
  logic [CNT_W-1:0] w_cnt_base;
  logic             w_len_base;
  logic             w_rng_base;
  logic             w_conf_base;
  logic             w_len_hit;
  logic             w_rng_hit;
  logic             w_conf_hit;
  logic             w_set;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_len_nxt;
  logic             w_rng_nxt;
  logic             w_conf_nxt;
  logic             w_ok_nxt;
  logic             w_commit_eff;

  logic             w_brd_rd_known;
  logic             w_brd_rd_val;
  logic             w_line_rd_known;
  logic             w_line_rd_val;
  logic             w_brd_known;
  logic             w_line_known_bit;
  logic [CELLS-1:0] w_line_known;
  logic [CELLS-1:0] w_line_val;
  logic [CELLS-1:0] w_brd_known_unused;
  logic [CELLS-1:0] w_brd_val_unused;

  assign w_beat      = i_in_valid && o_in_ready;
  assign w_first     = (r_state == S_IDLE);
  assign w_clear_brd = (r_state == S_IDLE) && i_clear;
  assign w_idx       = i_in_entry[IDX_W-1:0];
  assign w_v         = i_in_entry[IDX_W];
  assign w_in_range  = (32'(w_idx) < 32'(CELLS));

  // On the first beat of a line the accumulators restart from zero.
  assign w_cnt_base   = w_first ? '0 : r_count;
  assign w_len_base   = !w_first && r_err_len;
  assign w_rng_base   = !w_first && r_err_range;
  assign w_conf_base  = !w_first && r_conflict;
  assign w_commit_eff = w_first ? i_in_commit : r_commit;

  // A clear coinciding with a beat empties the board before the check, and the
  // line-local map is logically empty on the first beat.
  assign w_brd_known      = !w_clear_brd && w_brd_rd_known;
  assign w_line_known_bit = !w_first && w_line_rd_known;

  assign w_len_hit  = (w_cnt_base >= CNT_W'(MAX_LEN));
  assign w_rng_hit  = !w_len_hit && !w_in_range;
  assign w_conf_hit = !w_len_hit && w_in_range &&
                      ((w_brd_known && (w_brd_rd_val != w_v)) ||
                       (w_line_known_bit && (w_line_rd_val != w_v)));
  assign w_set      = w_beat && !w_len_hit && w_in_range && !w_conf_hit;

  assign w_cnt_nxt  = w_len_hit ? w_cnt_base : (w_cnt_base + CNT_W'(1));
  assign w_len_nxt  = w_len_base || w_len_hit;
  assign w_rng_nxt  = w_rng_base || w_rng_hit;
  assign w_conf_nxt = w_conf_base || w_conf_hit;
  assign w_ok_nxt   = !(w_len_nxt || w_rng_nxt || w_conf_nxt);

  cell_bitmap #(
    .IDX_W (IDX_W),
    .CELLS (CELLS)
  ) u_board (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_clear       (w_clear_brd),
    .i_set_en      (1'b0),
    .i_set_idx     ({IDX_W{1'b0}}),
    .i_set_val     (1'b0),
    .i_merge_en    (r_state == S_COMMIT),
    .i_merge_known (w_line_known),
    .i_merge_val   (w_line_val),
    .i_rd_idx      (w_idx),
    .o_rd_known    (w_brd_rd_known),
    .o_rd_val      (w_brd_rd_val),
    .o_known       (w_brd_known_unused),
    .o_val         (w_brd_val_unused)
  );

  cell_bitmap #(
    .IDX_W (IDX_W),
    .CELLS (CELLS)
  ) u_line (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_clear       (w_beat && w_first),
    .i_set_en      (w_set),
    .i_set_idx     (w_idx),
    .i_set_val     (w_v),
    .i_merge_en    (1'b0),
    .i_merge_known ({CELLS{1'b0}}),
    .i_merge_val   ({CELLS{1'b0}}),
    .i_rd_idx      (w_idx),
    .o_rd_known    (w_line_rd_known),
    .o_rd_val      (w_line_rd_val),
    .o_known       (w_line_known),
    .o_val         (w_line_val)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    o_res_valid = 1'b0;
    o_busy      = 1'b1;
    case (r_state)
      S_IDLE, S_STREAM: begin
        o_in_ready = 1'b1;
        o_busy     = (r_state != S_IDLE);
        if (w_beat && i_in_last) begin
          w_state_nxt = (w_commit_eff && w_ok_nxt) ? S_COMMIT : S_RESULT;
        end else if (w_beat) begin
          w_state_nxt = S_STREAM;
        end
      end
      S_COMMIT: begin
        w_state_nxt = S_RESULT;
      end
      S_RESULT: begin
        o_res_valid = 1'b1;
        if (i_res_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_err_len   <= 1'b0;
      r_err_range <= 1'b0;
      r_conflict  <= 1'b0;
      r_ok        <= 1'b0;
      r_commit    <= 1'b0;
    end else if (w_beat) begin
      r_count     <= w_cnt_nxt;
      r_err_len   <= w_len_nxt;
      r_err_range <= w_rng_nxt;
      r_conflict  <= w_conf_nxt;
      r_ok        <= w_ok_nxt;
      r_commit    <= w_commit_eff;
    end
  end

`ifdef CHECKER_CONFLICT_INFO_EN
  logic [IDX_W-1:0] r_conf_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_conf_idx <= '0;
    end else if (w_beat) begin
      if (w_conf_hit && !w_conf_base) begin
        r_conf_idx <= w_idx;
      end else if (w_first) begin
        r_conf_idx <= '0;
      end
    end
  end

  assign o_res_conflict_idx = r_conf_idx;
`else
  assign o_res_conflict_idx = '0;
`endif

  assign o_res_ok        = r_ok;
  assign o_res_err_range = r_err_range;
  assign o_res_err_len   = r_err_len;
  assign o_res_count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_line_consistency_checker.sv
`default_nettype none
// ============================================================================
// Module  : tb_line_consistency_checker
// Purpose : Self-checking bench for line_consistency_checker against a
//           behavioural board/line model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_line_consistency_checker;

  localparam int IDX_W   = 12;
  localparam int CELLS   = 256;
  localparam int MAX_LEN = 64;
  localparam int CNT_W   = 7;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_clear;
  logic             i_in_valid;
  logic             o_in_ready;
  logic [IDX_W:0]   i_in_entry;
  logic             i_in_last;
  logic             i_in_commit;
  logic             o_res_valid;
  logic             i_res_ready;
  logic             o_res_ok;
  logic             o_res_err_range;
  logic             o_res_err_len;
  logic [CNT_W-1:0] o_res_count;
  logic [IDX_W-1:0] o_res_conflict_idx;
  logic             o_busy;

  line_consistency_checker #(
    .IDX_W   (IDX_W),
    .CELLS   (CELLS),
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_clear            (i_clear),
    .i_in_valid         (i_in_valid),
    .o_in_ready         (o_in_ready),
    .i_in_entry         (i_in_entry),
    .i_in_last          (i_in_last),
    .i_in_commit        (i_in_commit),
    .o_res_valid        (o_res_valid),
    .i_res_ready        (i_res_ready),
    .o_res_ok           (o_res_ok),
    .o_res_err_range    (o_res_err_range),
    .o_res_err_len      (o_res_err_len),
    .o_res_count        (o_res_count),
    .o_res_conflict_idx (o_res_conflict_idx),
    .o_busy             (o_busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int q_idx[$];
  bit q_val[$];
  bit m_known[CELLS];
  bit m_val[CELLS];

  // Expected and observed result: {ok, err_range, err_len, count, conflict_idx}
  logic [21:0] e_res;
  logic [21:0] s_res;
  int          e_lat;
  int          s_lat;

  // Reference: apply the line rules to the board arrays, entry by entry.
  task automatic model_line(input bit commit, input bit clr);
    bit tk[CELLS];
    bit tv[CELLS];
    int cnt = 0;
    int ci  = 0;
    bit el = 0, er = 0, cf = 0, ok;
    for (int c = 0; c < CELLS; c++) begin
      tk[c] = 0;
      tv[c] = 0;
      if (clr) m_known[c] = 0;
    end
    for (int i = 0; i < q_idx.size(); i++) begin
      int x = q_idx[i];
      bit v = q_val[i];
      if (cnt >= MAX_LEN) el = 1;
      else if (x >= CELLS) er = 1;
      else if ((m_known[x] && m_val[x] != v) || (tk[x] && tv[x] != v)) begin
        if (!cf) ci = x;
        cf = 1;
      end else begin
        tk[x] = 1;
        tv[x] = v;
      end
      if (cnt < MAX_LEN) cnt++;
    end
    ok = !(cf || er || el);
    if (commit && ok) begin
      for (int c = 0; c < CELLS; c++) if (tk[c]) begin
        m_known[c] = 1;
        m_val[c]   = tv[c];
      end
    end
`ifndef CHECKER_CONFLICT_INFO_EN
    ci = 0;
`endif
    e_res = {ok, er, el, 7'(cnt), 12'(ci)};
    e_lat = (commit && ok) ? 2 : 1;
  endtask

  task automatic drive_line(input bit commit, input bit clr, input bit gaps);
    for (int i = 0; i < q_idx.size(); i++) begin
      bit rdy;
      int g = 0;
      i_in_valid  = 1'b1;
      i_in_entry  = {q_val[i], 12'(q_idx[i])};
      i_in_last   = (i == q_idx.size() - 1);
      i_in_commit = (i == 0) ? commit : ~commit;
      i_clear     = clr && (i == 0);
      do begin
        rdy = o_in_ready;
        @(posedge clk); #1;
        g++;
      end while (!rdy && g < 50);
      if (!rdy) begin
        n_tests++; n_fail++;
        $display("FAIL beat_accept: in_ready stayed %b, required 1", rdy);
      end
      i_in_valid = 1'b0;
      i_in_last  = 1'b0;
      i_clear    = 1'b0;
      if (gaps && i != q_idx.size() - 1 && $urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
    end
    s_lat = 1;
    while (!o_res_valid && s_lat < 20) begin
      @(posedge clk); #1;
      s_lat++;
    end
    if (!o_res_valid) begin
      n_tests++; n_fail++;
      $display("FAIL result_timeout: res_valid %b after %0d cycles, required 1", o_res_valid, s_lat);
    end
    s_res = {o_res_ok, o_res_err_range, o_res_err_len, o_res_count, o_res_conflict_idx};
  endtask

  task automatic ack;
    i_res_ready = 1'b1;
    @(posedge clk); #1;
    i_res_ready = 1'b0;
  endtask

  task automatic run_line(input bit commit, input bit clr, input bit gaps);
    model_line(commit, clr);
    drive_line(commit, clr, gaps);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < CELLS; c++) m_known[c] = 0;
  endtask

  task automatic test_reset;
    do_reset();
    n_tests++;
    if ({o_in_ready, o_res_valid, o_busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready/valid/busy=%b required 100", {o_in_ready, o_res_valid, o_busy});
    end
    n_tests++;
    if ({o_res_ok, o_res_err_range, o_res_err_len, o_res_count, o_res_conflict_idx} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_result: got %h required 0",
               {o_res_ok, o_res_err_range, o_res_err_len, o_res_count, o_res_conflict_idx});
    end
  endtask

  task automatic test_check_only;
    q_idx = '{3, 5, 7}; q_val = '{1, 0, 1};
    run_line(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (s_res !== e_res || s_lat !== e_lat) begin
      n_fail++;
      $display("FAIL check_only: got %h lat %0d required %h lat %0d", s_res, s_lat, e_res, e_lat);
    end
    ack();
    n_tests++;
    if (o_busy !== 1'b0 || o_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL after_ack: busy=%b ready=%b required 0 1", o_busy, o_in_ready);
    end
    // opposite values must still pass if the board stayed empty
    q_idx = '{3, 5, 7}; q_val = '{0, 1, 0};
    run_line(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (s_res !== e_res) begin
      n_fail++;
      $display("FAIL check_only_board_empty: got %h required %h", s_res, e_res);
    end
    ack();
  endtask

  task automatic test_commit_conflict;
    q_idx = '{3}; q_val = '{1};
    run_line(1'b1, 1'b0, 1'b0);
    n_tests++;
    if (s_res !== e_res || s_lat !== e_lat) begin
      n_fail++;
      $display("FAIL commit_line: got %h lat %0d required %h lat %0d", s_res, s_lat, e_res, e_lat);
    end
    ack();
    q_idx = '{8, 3}; q_val = '{0, 0};
    run_line(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (s_res !== e_res || s_lat !== e_lat) begin
      n_fail++;
      $display("FAIL board_conflict: got %h lat %0d required %h lat %0d", s_res, s_lat, e_res, e_lat);
    end
    ack();
    q_idx = '{3}; q_val = '{1};
    run_line(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (s_res !== e_res) begin
      n_fail++;
      $display("FAIL board_val_kept: got %h required %h", s_res, e_res);
    end
    ack();
  endtask

  task automatic test_self_conflict;
    q_idx = '{4, 4, 4}; q_val = '{1, 1, 0};
    run_line(1'b1, 1'b0, 1'b0);
    n_tests++;
    if (s_res !== e_res || s_lat !== e_lat) begin
      n_fail++;
      $display("FAIL self_conflict: got %h lat %0d required %h lat %0d", s_res, s_lat, e_res, e_lat);
    end
    ack();
    q_idx = '{4}; q_val = '{0};
    run_line(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (s_res !== e_res) begin
      n_fail++;
      $display("FAIL self_conflict_no_commit: got %h required %h", s_res, e_res);
    end
    ack();
  endtask

  task automatic test_range;
    q_idx = '{10, 300, 11}; q_val = '{1, 1, 0};
    run_line(1'b1, 1'b0, 1'b1);
    n_tests++;
    if (s_res !== e_res || s_lat !== e_lat) begin
      n_fail++;
      $display("FAIL range: got %h lat %0d required %h lat %0d", s_res, s_lat, e_res, e_lat);
    end
    ack();
  endtask

  task automatic test_len_hold;
    logic [21:0] held;
    q_idx.delete(); q_val.delete();
    for (int i = 0; i < MAX_LEN + 2; i++) begin
      q_idx.push_back(100 + (i % 20));
      q_val.push_back(bit'(i % 2));
    end
    run_line(1'b1, 1'b0, 1'b0);
    n_tests++;
    if (s_res !== e_res || s_lat !== e_lat) begin
      n_fail++;
      $display("FAIL max_len: got %h lat %0d required %h lat %0d", s_res, s_lat, e_res, e_lat);
    end
    held = s_res;
    i_in_valid = 1'b1;
    i_in_entry = {1'b1, 12'd50};
    i_in_last  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({o_res_ok, o_res_err_range, o_res_err_len, o_res_count, o_res_conflict_idx} !== held ||
          o_in_ready !== 1'b0 || o_res_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL result_hold: got %h ready %b valid %b required %h ready 0 valid 1",
                 {o_res_ok, o_res_err_range, o_res_err_len, o_res_count, o_res_conflict_idx},
                 o_in_ready, o_res_valid, held);
      end
    end
    i_in_valid = 1'b0;
    i_in_last  = 1'b0;
    ack();
    q_idx = '{100, 101}; q_val = '{1, 0};
    run_line(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (s_res !== e_res) begin
      n_fail++;
      $display("FAIL max_len_no_commit: got %h required %h", s_res, e_res);
    end
    ack();
  endtask

  task automatic test_reset_mid_stream;
    q_idx = '{3, 9}; q_val = '{1, 0};
    run_line(1'b1, 1'b0, 1'b0);
    ack();
    for (int i = 0; i < 3; i++) begin
      i_in_valid  = 1'b1;
      i_in_entry  = {1'b1, 12'(20 + i)};
      i_in_last   = 1'b0;
      i_in_commit = 1'b1;
      @(posedge clk); #1;
    end
    i_in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < CELLS; c++) m_known[c] = 0;
    n_tests++;
    if ({o_in_ready, o_res_valid, o_busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_mid_stream: ready/valid/busy=%b required 100", {o_in_ready, o_res_valid, o_busy});
    end
    q_idx = '{3, 9}; q_val = '{0, 1};
    run_line(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (s_res !== e_res) begin
      n_fail++;
      $display("FAIL board_cleared_by_reset: got %h required %h", s_res, e_res);
    end
    ack();
  endtask

  task automatic test_clear;
    q_idx = '{20}; q_val = '{1};
    run_line(1'b1, 1'b0, 1'b0);
    ack();
    q_idx = '{21}; q_val = '{0};
    run_line(1'b0, 1'b0, 1'b0);
    i_clear = 1'b1;
    repeat (3) @(posedge clk);
    #1 i_clear = 1'b0;
    ack();
    q_idx = '{20}; q_val = '{0};
    run_line(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (s_res !== e_res) begin
      n_fail++;
      $display("FAIL clear_in_result_ignored: got %h required %h", s_res, e_res);
    end
    ack();
    // clear together with the first beat: beat sees an empty board
    q_idx = '{20}; q_val = '{0};
    run_line(1'b0, 1'b1, 1'b0);
    n_tests++;
    if (s_res !== e_res) begin
      n_fail++;
      $display("FAIL clear_with_beat: got %h required %h", s_res, e_res);
    end
    ack();
  endtask

  task automatic test_random;
    for (int l = 0; l < 40; l++) begin
      int  len    = $urandom_range(1, 10);
      bit  commit = ($urandom_range(0, 9) < 7);
      bit  clr    = ($urandom_range(0, 9) == 0);
      q_idx.delete(); q_val.delete();
      for (int i = 0; i < len; i++) begin
        q_idx.push_back(($urandom_range(0, 9) == 0) ? int'($urandom_range(250, 300))
                                                    : int'($urandom_range(0, 15)));
        q_val.push_back(bit'($urandom_range(0, 1)));
      end
      run_line(commit, clr, 1'b1);
      n_tests++;
      if (s_res !== e_res || s_lat !== e_lat) begin
        n_fail++;
        $display("FAIL random_line_%0d: got %h lat %0d required %h lat %0d", l, s_res, s_lat, e_res, e_lat);
      end
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      ack();
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    i_clear     = 1'b0;
    i_in_valid  = 1'b0;
    i_in_entry  = '0;
    i_in_last   = 1'b0;
    i_in_commit = 1'b0;
    i_res_ready = 1'b0;
    test_reset();
    test_check_only();
    test_commit_conflict();
    test_self_conflict();
    test_range();
    test_len_hold();
    test_reset_mid_stream();
    test_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
